// File: rtl/cfg_chain_loader.sv
// Purpose : serialises parallel config words MSB-first onto the fabric configuration chain.
// Latency : a word accepted in cycle t drives its first bit in t+1; the next word_ready comes in t+WORD_W+1.
// Backpress: word_ready is high only in LOAD, and words wait there indefinitely; the chain itself cannot stall.
//
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   start             - one-cycle pulse; starts a pass from IDLE or DONE, ignored while busy
//   word_in/word_valid/word_ready - valid/ready word input
//   cfg_bit/cfg_en    - serial data and one-pulse-per-bit shift enable to the chain
//   busy/done         - pass in progress / pass complete (done held until next start)
//   cfg_sum           - XOR of the bits actually shifted, per word position (only with CFG_CHECKSUM_EN)
//
// Optional feature macro: CFG_CHECKSUM_EN
module cfg_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 72,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_bit,
    output logic              cfg_en,
    output logic              busy,
    output logic              done
`ifdef CFG_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0] cfg_sum
`endif
);

    localparam int IDX_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LP_CHAIN_LEN = CNT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] LP_WORD_W    = IDX_W'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [IDX_W-1:0]  r_word_idx;   // bits of the current word already driven
    logic              r_word_ready;
    logic              r_cfg_bit;
    logic              r_cfg_en;
    logic              r_busy;
    logic              r_done;
`ifdef CFG_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;
    assign cfg_sum = r_sum;
`endif

    assign word_ready = r_word_ready;
    assign cfg_bit    = r_cfg_bit;
    assign cfg_en     = r_cfg_en;
    assign busy       = r_busy;
    assign done       = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_word_idx   <= '0;
            r_word_ready <= 1'b0;
            r_cfg_bit    <= 1'b0;
            r_cfg_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_LOAD;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_word_ready <= 1'b1;
                        r_bit_cnt    <= '0;
                        r_word_idx   <= '0;
`ifdef CFG_CHECKSUM_EN
                        r_sum        <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    // word_ready is registered high throughout LOAD, so valid alone completes the handshake.
                    // The MSB goes straight to the output register so it appears the cycle after acceptance.
                    if (word_valid) begin
                        r_state      <= S_SHIFT;
                        r_word_ready <= 1'b0;
                        r_cfg_en     <= 1'b1;
                        r_cfg_bit    <= word_in[WORD_W-1];
                        r_shift      <= word_in << 1;
                        r_bit_cnt    <= r_bit_cnt + 1'b1;
                        r_word_idx   <= IDX_W'(1);
`ifdef CFG_CHECKSUM_EN
                        r_sum        <= r_sum ^ word_in;
`endif
                    end
                end
                S_SHIFT: begin
                    // Chain length wins over word boundary: a partial last word is cut short here.
                    if (r_bit_cnt == LP_CHAIN_LEN) begin
                        r_state   <= S_DONE;
                        r_cfg_en  <= 1'b0;
                        r_cfg_bit <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
`ifdef CFG_CHECKSUM_EN
                        // r_shift holds the unsent low bits left-aligned; undo their contribution.
                        r_sum     <= r_sum ^ (r_shift >> r_word_idx);
`endif
                    end else if (r_word_idx == LP_WORD_W) begin
                        r_state      <= S_LOAD;
                        r_cfg_en     <= 1'b0;
                        r_cfg_bit    <= 1'b0;
                        r_word_ready <= 1'b1;
                    end else begin
                        r_cfg_bit  <= r_shift[WORD_W-1];
                        r_shift    <= r_shift << 1;
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_word_idx <= r_word_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
module tb_cfg_chain_loader;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_s[2];
    logic       start_s[2];
    logic       valid_s[2];
    logic [7:0] win_s[2];
    logic       rdy_s[2];
    logic       bit_s[2];
    logic       en_s[2];
    logic       busy_s[2];
    logic       done_s[2];
`ifdef CFG_CHECKSUM_EN
    logic [7:0] sum_s[2];
`endif

    // dut 0: chain of 24 (whole words); dut 1: chain of 20 (truncated last word)
    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(24), .CNT_W(7)) u_dut0 (
        .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .word_in(win_s[0]),
        .word_valid(valid_s[0]), .word_ready(rdy_s[0]), .cfg_bit(bit_s[0]),
        .cfg_en(en_s[0]), .busy(busy_s[0]), .done(done_s[0])
`ifdef CFG_CHECKSUM_EN
        , .cfg_sum(sum_s[0])
`endif
    );
    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(7)) u_dut1 (
        .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .word_in(win_s[1]),
        .word_valid(valid_s[1]), .word_ready(rdy_s[1]), .cfg_bit(bit_s[1]),
        .cfg_en(en_s[1]), .busy(busy_s[1]), .done(done_s[1])
`ifdef CFG_CHECKSUM_EN
        , .cfg_sum(sum_s[1])
`endif
    );

    int nvec = 0;
    int nfail = 0;

    // expected serial bits per dut, pushed by the stimulus side
    bit q0[$];
    bit q1[$];

    // per-cycle reference model state
    bit         m_active[2];
    bit         m_done[2];
    int         m_left[2];
    int         m_sent[2];
    logic [7:0] m_sum[2];
    bit         e_en[2];
    bit         e_rdy[2];
    bit         e_busy[2];
    bit         e_done[2];

    function automatic int clen(int d);
        return (d == 0) ? 24 : 20;
    endfunction

    function automatic void push_bit(int d, bit b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endfunction

    function automatic logic pop_bit(int d);
        if (d == 0) begin
            if (q0.size() == 0) return 1'bx;
            return q0.pop_front();
        end
        if (q1.size() == 0) return 1'bx;
        return q1.pop_front();
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qflush(int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s dut%0d t=%0t got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Compare this cycle's outputs, then advance the model using the inputs the DUT sees at the next edge.
    task automatic step(input int d);
        logic       eb;
        int         n;
        logic [7:0] ones;
        chk("busy", d, 32'(busy_s[d]), 32'(e_busy[d]));
        chk("done", d, 32'(done_s[d]), 32'(e_done[d]));
        chk("word_ready", d, 32'(rdy_s[d]), 32'(e_rdy[d]));
        chk("cfg_en", d, 32'(en_s[d]), 32'(e_en[d]));
        if (e_en[d]) begin
            eb = pop_bit(d);
            chk("cfg_bit", d, 32'(bit_s[d]), 32'(eb));
        end else begin
            chk("cfg_bit_idle", d, 32'(bit_s[d]), 32'd0);
        end
`ifdef CFG_CHECKSUM_EN
        if (e_done[d]) chk("cfg_sum", d, 32'(sum_s[d]), 32'(m_sum[d]));
`endif
        if (reset_s[d]) begin
            m_active[d] = 1'b0;
            m_done[d]   = 1'b0;
            m_left[d]   = 0;
            m_sent[d]   = 0;
            m_sum[d]    = 8'h00;
            qflush(d);
        end else if (!m_active[d]) begin
            if (start_s[d]) begin
                m_active[d] = 1'b1;
                m_done[d]   = 1'b0;
                m_left[d]   = 0;
                m_sent[d]   = 0;
                m_sum[d]    = 8'h00;
            end
        end else if (m_left[d] > 0) begin
            m_left[d]--;
            m_sent[d]++;
            if (m_left[d] == 0 && m_sent[d] == clen(d)) begin
                m_active[d] = 1'b0;
                m_done[d]   = 1'b1;
            end
        end else if (valid_s[d]) begin
            n = clen(d) - m_sent[d];
            if (n > W) n = W;
            m_left[d] = n;
            ones = 8'hFF;
            m_sum[d] = m_sum[d] ^ (win_s[d] & (ones << (W - n)));
        end
        e_en[d]   = (m_left[d] > 0);
        e_rdy[d]  = m_active[d] && (m_left[d] == 0);
        e_busy[d] = m_active[d];
        e_done[d] = m_done[d];
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) step(d);
        end
    endtask

    task automatic send_word(input int d, input logic [7:0] w, input int gap, inout int pushed);
        int k;
        valid_s[d] = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        for (int i = W - 1; i >= 0; i--) begin
            if (pushed < clen(d)) begin
                push_bit(d, w[i]);
                pushed++;
            end
        end
        win_s[d]   = w;
        valid_s[d] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!rdy_s[d] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!rdy_s[d]) chk("handshake_wait", d, 32'(rdy_s[d]), 32'd1);
        @(posedge clk);
        #1;
        valid_s[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk);
        #1;
        start_s[d] = 1'b1;
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
    endtask

    // gap < 0 selects a random 0..6 cycle gap before each word
    task automatic run_pass(input int d, input bit fixed, input int gap, input bit start_valid, input bit start_in_shift);
        logic [7:0] words[3];
        int         pushed;
        int         k;
        int         g;
        pushed = 0;
        for (int i = 0; i < 3; i++) words[i] = fixed ? 8'h00 : 8'($urandom);
        if (fixed) begin
            words[0] = 8'hA5;
            words[1] = 8'h3C;
            words[2] = 8'hF0;
        end
        @(posedge clk);
        #1;
        start_s[d] = 1'b1;
        if (start_valid) begin
            valid_s[d] = 1'b1;
            win_s[d]   = words[0];
        end
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 6)) : gap;
            if (i == 0 && start_valid) g = 0;
            send_word(d, words[i], g, pushed);
            if (i == 0 && start_in_shift) begin
                start_s[d] = 1'b1;
                @(posedge clk);
                #1;
                start_s[d] = 1'b0;
            end
        end
        k = 0;
        @(negedge clk);
        while (!done_s[d] && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("pass_done", d, 32'(done_s[d]), 32'd1);
        chk("leftover_bits", d, 32'(qsize(d)), 32'd0);
    endtask

    task automatic reset_mid_pass(input int d);
        int pushed;
        pushed = 0;
        pulse_start(d);
        send_word(d, 8'hA5, 0, pushed);
        send_word(d, 8'h3C, 0, pushed);
        // now in the cycle carrying pulse 9; reset lands right after pulse 10
        @(posedge clk);
        #1;
        reset_s[d] = 1'b1;
        @(posedge clk);
        #1;
        reset_s[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_s[d]  = 1'b1;
            start_s[d]  = 1'b0;
            valid_s[d]  = 1'b0;
            win_s[d]    = 8'h00;
            m_active[d] = 1'b0;
            m_done[d]   = 1'b0;
            m_left[d]   = 0;
            m_sent[d]   = 0;
            m_sum[d]    = 8'h00;
            e_en[d]     = 1'b0;
            e_rdy[d]    = 1'b0;
            e_busy[d]   = 1'b0;
            e_done[d]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        fork
            monitor();
            begin
                @(posedge clk);
                #1;
                reset_s[0] = 1'b0;
                reset_s[1] = 1'b0;
                repeat (3) @(posedge clk);
                run_pass(0, 1'b1, 0, 1'b0, 1'b0);   // A5 3C F0 on a 24-bit chain
                run_pass(1, 1'b1, 0, 1'b0, 1'b0);   // same words, 20-bit chain
                run_pass(0, 1'b1, 5, 1'b0, 1'b0);   // 5-cycle valid gaps in LOAD
                run_pass(0, 1'b1, 0, 1'b0, 1'b1);   // start pulsed mid-shift
                reset_mid_pass(0);
                run_pass(0, 1'b1, 0, 1'b0, 1'b0);   // full pass after reset
                run_pass(0, 1'b1, 0, 1'b0, 1'b0);   // start from DONE, identical pass
                run_pass(1, 1'b1, 2, 1'b1, 1'b0);   // start and valid together in IDLE
                run_pass(1, 1'b1, 0, 1'b0, 1'b0);
                for (int p = 0; p < 30; p++) begin
                    run_pass(p % 2, 1'b0, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                repeat (3) @(posedge clk);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
